// File: rtl/senha_pkg.sv
// Shared definitions for the password-checker session sequencer.
// Build option: SENHA_LOCKOUT_EN adds the lockout state after repeated failures.
package senha_pkg;

   localparam logic [2:0] ACSS_PEND = 3'b000;
   localparam logic [2:0] ACSS_OK   = 3'b100;
   localparam logic [2:0] ACSS_ERR  = 3'b001;
   localparam logic [2:0] ACSS_TMO  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_RELEASE = 3'd2,
`ifdef SENHA_LOCKOUT_EN
      ST_OPEN    = 3'd3,
      ST_LOCKOUT = 3'd4
`else
      ST_OPEN    = 3'd3
`endif
   } state_t;

   // Any nonzero verdict that is neither a grant nor a timeout is a failure.
   function automatic logic is_failure(input logic [2:0] v);
      return (v == ACSS_ERR) ||
             ((v != ACSS_PEND) && (v != ACSS_OK) && (v != ACSS_TMO));
   endfunction

   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

endpackage

// File: rtl/senha_deb.sv
// Confirm-button conditioner: 2-FF synchronizer, stable-count filter and
// a one-cycle pulse on each filtered press.
module senha_deb #(
   parameter int DEB_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic conf_raw,
   output logic pulse
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // The level flips only after DEB_CYC consecutive synchronized samples disagree with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync1 <= conf_raw;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYC - 1)) begin
            level <= sync2;
            cnt   <= '0;
            pulse <= sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/senha_ctrl.sv
// Session sequencer between the board buttons and the password checker.
// Build option: SENHA_LOCKOUT_EN enables the LOCKOUT state and its timer.
module senha_ctrl
   import senha_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000,
   parameter int DEB_CYC     = 16,
   parameter int OPEN_CYC    = 500,
   parameter int LOCK_CYC    = 5000,
   parameter int MAX_FAIL    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       conf_raw,
   input  logic [2:0] acss,
   output logic       sinc,
   output logic       temp,
   output logic       dcont,
   output logic       open,
   output logic       locked,
   output logic [1:0] fail_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int OW = $clog2(OPEN_CYC + 1);

   state_t        state, state_nxt;
   logic [TW-1:0] ent_tmr, ent_tmr_nxt;
   logic [OW-1:0] open_tmr, open_tmr_nxt;
   logic          temp_nxt;
   logic [2:0]    verdict, verdict_nxt;
   logic [1:0]    fail_nxt;
   logic          pulse;

`ifdef SENHA_LOCKOUT_EN
   localparam int LW = $clog2(LOCK_CYC + 1);
   logic [LW-1:0] lock_tmr, lock_tmr_nxt;
`endif

   senha_deb #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .conf_raw (conf_raw),
      .pulse    (pulse)
   );

   // Presses only reach the checker while an entry is live and not yet timed out.
   assign dcont = pulse & (state == ST_ENTRY) & ~temp;
   assign sinc  = (state == ST_ENTRY);
   assign open  = (state == ST_OPEN);
`ifdef SENHA_LOCKOUT_EN
   assign locked = (state == ST_LOCKOUT);
`else
   // Constant low; the lockout parameters stay referenced so both builds share one interface.
   assign locked = 1'b0 & (LOCK_CYC > 0) & (MAX_FAIL > 0);
`endif

   always_comb begin
      state_nxt    = state;
      ent_tmr_nxt  = ent_tmr;
      open_tmr_nxt = open_tmr;
      temp_nxt     = temp;
      verdict_nxt  = verdict;
      fail_nxt     = fail_cnt;
`ifdef SENHA_LOCKOUT_EN
      lock_tmr_nxt = lock_tmr;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt   = ST_ENTRY;
               ent_tmr_nxt = '0;
               temp_nxt    = 1'b0;
            end
         end
         ST_ENTRY: begin
            if (acss != ACSS_PEND) begin
               verdict_nxt = acss;
               state_nxt   = ST_RELEASE;
               ent_tmr_nxt = '0;
               temp_nxt    = 1'b0;
            end else if (dcont) begin
               ent_tmr_nxt = '0;
            end else if (ent_tmr == TW'(TIMEOUT_CYC - 1)) begin
               temp_nxt = 1'b1;
            end else begin
               ent_tmr_nxt = ent_tmr + TW'(1);
            end
         end
         ST_RELEASE: begin
            state_nxt = ST_IDLE;
            if (verdict == ACSS_OK) begin
               fail_nxt     = 2'd0;
               open_tmr_nxt = '0;
               state_nxt    = ST_OPEN;
            end else if (is_failure(verdict)) begin
               fail_nxt = sat_inc2(fail_cnt);
`ifdef SENHA_LOCKOUT_EN
               if (fail_nxt == 2'(MAX_FAIL)) begin
                  lock_tmr_nxt = '0;
                  state_nxt    = ST_LOCKOUT;
               end
`endif
            end
         end
         ST_OPEN: begin
            if (open_tmr == OW'(OPEN_CYC - 1)) begin
               open_tmr_nxt = '0;
               state_nxt    = ST_IDLE;
            end else begin
               open_tmr_nxt = open_tmr + OW'(1);
            end
         end
`ifdef SENHA_LOCKOUT_EN
         ST_LOCKOUT: begin
            if (lock_tmr == LW'(LOCK_CYC - 1)) begin
               lock_tmr_nxt = '0;
               fail_nxt     = 2'd0;
               state_nxt    = ST_IDLE;
            end else begin
               lock_tmr_nxt = lock_tmr + LW'(1);
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ent_tmr  <= '0;
         open_tmr <= '0;
         temp     <= 1'b0;
         verdict  <= ACSS_PEND;
         fail_cnt <= 2'd0;
`ifdef SENHA_LOCKOUT_EN
         lock_tmr <= '0;
`endif
      end else begin
         state    <= state_nxt;
         ent_tmr  <= ent_tmr_nxt;
         open_tmr <= open_tmr_nxt;
         temp     <= temp_nxt;
         verdict  <= verdict_nxt;
         fail_cnt <= fail_nxt;
`ifdef SENHA_LOCKOUT_EN
         lock_tmr <= lock_tmr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_senha_ctrl.sv
// Bench for senha_ctrl: password-checker stand-in, behavioural session model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_senha_ctrl;

   localparam int TIMEOUT_CYC = 1000;
   localparam int DEB_CYC     = 16;
   localparam int OPEN_CYC    = 500;
   localparam int LOCK_CYC    = 5000;
   localparam int MAX_FAIL    = 3;
`ifdef SENHA_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif
   localparam logic [1:0] PW [4] = '{2'd0, 2'd3, 2'd2, 2'd1};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       conf_raw = 1'b0;
   logic [2:0] acss = 3'b000;
   logic [1:0] bot = 2'd0;
   logic       sinc, temp, dcont, open, locked;
   logic [1:0] fail_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   senha_ctrl #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .DEB_CYC     (DEB_CYC),
      .OPEN_CYC    (OPEN_CYC),
      .LOCK_CYC    (LOCK_CYC),
      .MAX_FAIL    (MAX_FAIL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .conf_raw (conf_raw),
      .acss     (acss),
      .sinc     (sinc),
      .temp     (temp),
      .dcont    (dcont),
      .open     (open),
      .locked   (locked),
      .fail_cnt (fail_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: session phase, cycles without a press, remaining dwell time.
   typedef enum {P_IDLE, P_ENTRY, P_REL, P_OPEN, P_LOCK} phase_t;
   phase_t     m_phase = P_IDLE;
   int         m_quiet = 0;
   int         m_left  = 0;
   int         m_fails = 0;
   logic [2:0] m_verdict = 3'b000;
   logic       m_lvl = 1'b0;
   logic       m_pulse = 1'b0;
   logic       m_hist [DEB_CYC+2];
   bit         model_ok = 1'b0;
   bit         cur_dcont, all_diff;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_phase = P_IDLE; m_quiet = 0; m_left = 0; m_fails = 0;
            m_verdict = 3'b000; m_lvl = 1'b0; m_pulse = 1'b0;
            foreach (m_hist[i]) m_hist[i] = 1'b0;
         end else begin
            cur_dcont = m_pulse && (m_phase == P_ENTRY) && (m_quiet < TIMEOUT_CYC);
            case (m_phase)
               P_IDLE: if (start) begin m_phase = P_ENTRY; m_quiet = 0; end
               P_ENTRY: begin
                  if (acss != 3'b000) begin m_verdict = acss; m_phase = P_REL; end
                  else if (cur_dcont) m_quiet = 0;
                  else if (m_quiet < TIMEOUT_CYC) m_quiet++;
               end
               P_REL: begin
                  if (m_verdict == 3'b100) begin
                     m_fails = 0; m_phase = P_OPEN; m_left = OPEN_CYC;
                  end else if (m_verdict == 3'b010) begin
                     m_phase = P_IDLE;
                  end else begin
                     m_fails = (m_fails < 3) ? m_fails + 1 : 3;
                     m_left  = LOCK_CYC;
                     m_phase = (LOCK_EN && m_fails == MAX_FAIL) ? P_LOCK : P_IDLE;
                  end
               end
               P_OPEN: begin m_left--; if (m_left == 0) m_phase = P_IDLE; end
               P_LOCK: begin
                  m_left--;
                  if (m_left == 0) begin m_phase = P_IDLE; m_fails = 0; end
               end
            endcase
            // Raw samples reach the filter two edges late; a flip needs DEB_CYC disagreeing samples.
            for (int i = DEB_CYC + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = conf_raw;
            all_diff = 1'b1;
            for (int i = 2; i < DEB_CYC + 2; i++) if (m_hist[i] == m_lvl) all_diff = 1'b0;
            m_pulse = all_diff && !m_lvl;
            if (all_diff) m_lvl = !m_lvl;
         end
         model_ok = 1'b1;
      end
   end

   // Measurements of DUT activity used by the directed literal checks.
   int open_run = 0, last_open_run = 0, open_total = 0;
   int lock_run = 0, last_lock_run = 0;
   int dcont_total = 0, quiet = 0, last_temp_gap = -1;
   logic prev_temp = 1'b0;

   // Compare process, checker stand-in and measurements, all at the falling edge.
   initial begin
      int idx;
      logic e_temp;
      idx = 0;
      forever begin
         @(negedge clk);
         if (model_ok) begin
            e_temp = (m_phase == P_ENTRY) && (m_quiet >= TIMEOUT_CYC);
            check("sinc",     32'(sinc),     32'(m_phase == P_ENTRY));
            check("temp",     32'(temp),     32'(e_temp));
            check("dcont",    32'(dcont),    32'(m_pulse && m_phase == P_ENTRY && !e_temp));
            check("open",     32'(open),     32'(m_phase == P_OPEN));
            check("locked",   32'(locked),   32'(m_phase == P_LOCK));
            check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
         end
         if (!sinc) begin
            idx = 0; acss = 3'b000;
         end else if (acss == 3'b000) begin
            if (temp) acss = 3'b010;
            else if (dcont) begin
               if (bot == PW[idx]) begin idx++; if (idx == 4) acss = 3'b100; end
               else acss = 3'b001;
            end
         end
         if (open) begin open_run++; open_total++; end
         else if (open_run > 0) begin last_open_run = open_run; open_run = 0; end
         if (locked) lock_run++;
         else if (lock_run > 0) begin last_lock_run = lock_run; lock_run = 0; end
         if (dcont) dcont_total++;
         if (!sinc) quiet = 0;
         else if (!temp) quiet = dcont ? 0 : quiet + 1;
         if (temp && !prev_temp) last_temp_gap = quiet;
         prev_temp = temp;
      end
   end

   task automatic begin_session();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic press(input logic [1:0] code, input bit bouncy);
      int nb;
      bot = code;
      if (bouncy) begin
         nb = $urandom_range(2, 5);
         for (int i = 0; i < nb; i++) begin
            conf_raw = ~conf_raw;
            repeat ($urandom_range(1, DEB_CYC - 4)) @(negedge clk);
         end
      end
      conf_raw = 1'b1; repeat (DEB_CYC + 6) @(negedge clk);
      conf_raw = 1'b0; repeat (DEB_CYC + 6) @(negedge clk);
   endtask

   // Waits for two consecutive quiet cycles; optionally pokes start while busy.
   task automatic wait_idle(input bit poke);
      int zeros = 0;
      int n = 0;
      while (zeros < 2 && n < 8000) begin
         @(negedge clk); n++;
         start = 1'b0;
         if (sinc || open || locked) zeros = 0; else zeros++;
         if (poke && (open || locked) && $urandom_range(0, 7) == 0) start = 1'b1;
      end
      start = 1'b0;
      check("idle_reached", 32'(zeros >= 2), 32'd1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, n, nd;
      logic [1:0] code;
      bit good;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sinc", 32'(sinc), 32'd0);
      check("rst_temp", 32'(temp), 32'd0);
      check("rst_dcont", 32'(dcont), 32'd0);
      check("rst_open", 32'(open), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_fail_cnt", 32'(fail_cnt), 32'd0);

      // Correct entry: 00,11,10,01 opens the door for OPEN_CYC cycles.
      begin_session();
      for (int d = 0; d < 4; d++) press(PW[d], 1'b0);
      wait_idle(1'b0);
      check("grant_open_len", 32'(last_open_run), 32'(OPEN_CYC));
      check("grant_fail_cnt", 32'(fail_cnt), 32'd0);

      // Wrong first digit.
      begin_session();
      press(2'd1, 1'b0);
      wait_idle(1'b0);
      check("wrong_fail_cnt", 32'(fail_cnt), 32'd1);
      check("wrong_no_open", 32'(open_total), 32'(OPEN_CYC));

      // One good digit then silence: timeout, failures unchanged.
      begin_session();
      press(PW[0], 1'b0);
      wait_idle(1'b0);
      check("tmo_gap", 32'(last_temp_gap), 32'(TIMEOUT_CYC));
      check("tmo_fail_cnt", 32'(fail_cnt), 32'd1);

      // Two more failures reach the limit.
      for (int k = 0; k < 2; k++) begin
         begin_session();
         press(2'd2, 1'b0);
         if (k == 0) wait_idle(1'b0);
      end
`ifdef SENHA_LOCKOUT_EN
      n = 0;
      while (!locked && n < 200) begin @(negedge clk); n++; end
      check("lock_entered", 32'(locked), 32'd1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_idle(1'b1);
      check("lock_len", 32'(last_lock_run), 32'(LOCK_CYC));
      check("lock_fail_cnt", 32'(fail_cnt), 32'd0);
`else
      wait_idle(1'b0);
      check("nolock_locked", 32'(locked), 32'd0);
      check("nolock_fail_cnt", 32'(fail_cnt), 32'd3);
`endif

      // Bounce: toggling every 3 cycles yields nothing until held high.
      begin_session();
      bot = PW[0];
      d0 = dcont_total;
      for (int i = 0; i < 40; i += 3) begin conf_raw = ~conf_raw; repeat (3) @(negedge clk); end
      conf_raw = 1'b1; repeat (50) @(negedge clk);
      check("bounce_one_pulse", 32'(dcont_total - d0), 32'd1);
      conf_raw = 1'b0; repeat (30) @(negedge clk);
      bot = PW[1];
      conf_raw = 1'b1; repeat (30) @(negedge clk);
      check("bounce_second_pulse", 32'(dcont_total - d0), 32'd2);
      conf_raw = 1'b0;
      wait_idle(1'b0);

      // Reset in the middle of an entry, after one more failure.
      begin_session();
      press(2'd3, 1'b0);
      wait_idle(1'b0);
      begin_session();
      repeat (400) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_sinc", 32'(sinc), 32'd0);
      check("arst_temp", 32'(temp), 32'd0);
      check("arst_dcont", 32'(dcont), 32'd0);
      check("arst_open", 32'(open), 32'd0);
      check("arst_locked", 32'(locked), 32'd0);
      check("arst_fail_cnt", 32'(fail_cnt), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      begin_session();
      wait_idle(1'b0);
      check("arst_restart_gap", 32'(last_temp_gap), 32'(TIMEOUT_CYC));

      // Randomised attempts against the model.
      for (int a = 0; a < 12; a++) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         begin_session();
         nd = $urandom_range(0, 4);
         good = 1'($urandom_range(0, 1));
         for (int d = 0; d < nd; d++) begin
            code = good ? PW[d] : 2'($urandom_range(0, 3));
            press(code, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 30)) @(negedge clk);
         end
         wait_idle(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
